kmac_state_snapshot: RTL and testbench

Holds the Keccak state for software readback. It captures the 1600-bit state (one copy per share) from the Keccak core whenever a squeeze completes, and holds it stable for the TL-UL state-read window. When software signals completion, it wipes the stored state lane by lane with entropy. It sits between the Keccak round logic and the state-read TL-UL window, driving that window's `state_i` input.

---
 rtl/kmac_state_snapshot_if.sv | 27 ++
 rtl/kmac_state_snapshot.sv | 105 ++++++++++
 tb/tb_kmac_state_snapshot.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/kmac_state_snapshot_if.sv
// Interface between the Keccak core / software control and the state snapshot.
// The master side drives the capture/run/done/wipe inputs. The slave side is
// the snapshot block, which drives the held state and the status flags.
interface kmac_state_snapshot_if #(
  parameter int Share  = 1,
  parameter int StateW = 1600
);
  logic                          state_valid_i;
  logic [Share-1:0][StateW-1:0]  state_i;
  logic                          run_i;
  logic                          done_i;
  logic [63:0]                   wipe_data_i;
  logic [Share-1:0][StateW-1:0]  state_o;
  logic                          state_valid_o;
  logic                          busy_o;
  logic                          err_o;

  modport master (
    output state_valid_i, state_i, run_i, done_i, wipe_data_i,
    input  state_o, state_valid_o, busy_o, err_o
  );

  modport slave (
    input  state_valid_i, state_i, run_i, done_i, wipe_data_i,
    output state_o, state_valid_o, busy_o, err_o
  );
endinterface

// File: rtl/kmac_state_snapshot.sv
// Keccak state snapshot for software readback. Captures every share of the
// state when a squeeze completes and holds it for the state-read window. On
// done, overwrites one 64-bit lane per cycle (all shares at once) with
// entropy. The bus interface's Share parameter must equal (EnMasking ? 2 : 1).
module kmac_state_snapshot #(
  parameter logic EnMasking = 1'b0
) (
  input logic                    clk_i,
  input logic                    rst_i,
  kmac_state_snapshot_if.slave   bus
);
  localparam int Share    = EnMasking ? 2 : 1;
  localparam int NumLanes = 25;
  localparam int StateW   = 64 * NumLanes;
  localparam logic [4:0] LastLane = 5'(NumLanes - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_WIPE  = 2'd2
  } st_e;

  st_e         st_q, st_d;
  logic [4:0]  cnt_q;
  logic        capture;
  logic        wipe_en;
  logic        err_d;
  logic        err_q;
  logic [Share-1:0][NumLanes-1:0][63:0] store_q;

  // State register plus the registered drop-flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q  <= ST_EMPTY;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      err_q <= err_d;
    end
  end

  // Next state and control strobes. done beats capture, capture beats run.
  always_comb begin
    st_d    = st_q;
    capture = 1'b0;
    wipe_en = 1'b0;
    err_d   = 1'b0;
    unique case (st_q)
      ST_EMPTY, ST_FULL: begin
        if (bus.done_i) begin
          st_d  = ST_WIPE;
          err_d = bus.state_valid_i;
        end else if (bus.state_valid_i) begin
          st_d    = ST_FULL;
          capture = 1'b1;
        end else if (bus.run_i) begin
          st_d = ST_EMPTY;
        end
      end
      ST_WIPE: begin
        // Captures arriving mid-wipe are dropped and flagged; run/done ignored.
        wipe_en = 1'b1;
        err_d   = bus.state_valid_i;
        if (cnt_q == LastLane) st_d = ST_EMPTY;
      end
      default: st_d = ST_EMPTY;
    endcase
  end

  // Lane counter: walks 0..24 only while wiping, parked at 0 otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (wipe_en && cnt_q != LastLane) begin
      cnt_q <= cnt_q + 5'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  // Held state: full capture of all shares, or one lane of every share wiped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      store_q <= '0;
    end else begin
      for (int s = 0; s < Share; s++) begin
        for (int l = 0; l < NumLanes; l++) begin
          if (capture) begin
            store_q[s][l] <= bus.state_i[s][64*l +: 64];
          end else if (wipe_en && cnt_q == 5'(l)) begin
            store_q[s][l] <= bus.wipe_data_i;
          end
        end
      end
    end
  end

  assign bus.state_o       = store_q;
  assign bus.state_valid_o = (st_q == ST_FULL);
  assign bus.busy_o        = (st_q == ST_WIPE);
  assign bus.err_o         = err_q;

  logic unused_w;
  assign unused_w = ^StateW;
endmodule

// File: tb/tb_kmac_state_snapshot.sv
// Bench for kmac_state_snapshot with two shares. A lane-array model tracks
// "holding fresh data" and "wipe cycles remaining" and is stepped each clock.
module tb_kmac_state_snapshot;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  kmac_state_snapshot_if #(.Share(2)) bus ();

  kmac_state_snapshot #(.EnMasking(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [63:0] m_lane [2][25];
  bit          m_full;
  int          m_wipe_left;
  bit          m_err;

  function automatic logic [1:0][24:0][63:0] m_pack();
    logic [1:0][24:0][63:0] p;
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 25; l++) p[s][l] = m_lane[s][l];
    return p;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 25; l++) m_lane[s][l] = '0;
    m_full = 0; m_wipe_left = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input bit r, input bit d, input logic [63:0] wd);
    m_err = 0;
    if (m_wipe_left > 0) begin
      for (int s = 0; s < 2; s++) m_lane[s][25 - m_wipe_left] = wd;
      m_wipe_left--;
      m_err = v;
    end else if (d) begin
      m_wipe_left = 25;
      m_full = 0;
      m_err = v;
    end else if (v) begin
      for (int s = 0; s < 2; s++)
        for (int l = 0; l < 25; l++) m_lane[s][l] = bus.state_i[s][64*l +: 64];
      m_full = 1;
    end else if (r) begin
      m_full = 0;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [1:0][24:0][63:0] obs, exp;
    obs = bus.state_o;
    exp = m_pack();
    checks++;
    assert (obs === exp) else begin
      errors++;
      for (int i = 0; i < 50; i++) begin
        if (obs[i/25][i%25] !== exp[i/25][i%25]) begin
          $error("FAIL %s share %0d lane %0d obs=%h exp=%h", tag, i/25, i%25,
                 obs[i/25][i%25], exp[i/25][i%25]);
          break;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk1({tag, ".valid"}, bus.state_valid_o, m_full);
    chk1({tag, ".busy"},  bus.busy_o, m_wipe_left > 0);
    chk1({tag, ".err"},   bus.err_o, m_err);
    chk_state({tag, ".state"});
  endtask

  task automatic fill(input logic [7:0] b0, input logic [7:0] b1);
    bus.state_i[0] = {200{b0}};
    bus.state_i[1] = {200{b1}};
  endtask

  task automatic fill_rand();
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 25; l++) bus.state_i[s][64*l +: 64] = {$urandom, $urandom};
  endtask

  // One clock: present inputs, step model at the edge, compare 1 time unit later.
  task automatic cyc(input string tag, input bit v, input bit r, input bit d,
                     input logic [63:0] wd);
    bus.state_valid_i = v; bus.run_i = r; bus.done_i = d; bus.wipe_data_i = wd;
    @(posedge clk);
    model_step(v, r, d, wd);
    #1;
    check_all(tag);
    bus.state_valid_i = 0; bus.run_i = 0; bus.done_i = 0;
  endtask

  initial begin
    bus.state_valid_i = 0; bus.run_i = 0; bus.done_i = 0; bus.wipe_data_i = '0;
    fill(8'h00, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 0;

    // Capture, then run drops valid but keeps data
    fill(8'hA5, 8'h5A);
    repeat (3) cyc("idle", 0, 0, 0, '0);
    cyc("capture", 1, 0, 0, '0);
    chk64("cap.s0l0",  bus.state_o[0][63:0], 64'hA5A5_A5A5_A5A5_A5A5);
    chk64("cap.s1l24", bus.state_o[1][1599:1536], 64'h5A5A_5A5A_5A5A_5A5A);
    fill(8'h11, 8'h22);
    repeat (4) cyc("hold", 0, 0, 0, '0);
    cyc("run", 0, 1, 0, '0);
    chk64("run.s0l3", bus.state_o[0][255:192], 64'hA5A5_A5A5_A5A5_A5A5);

    // Wipe with lane-indexed words; dropped capture at wipe cycle 5, done/run at 10
    cyc("recap", 1, 0, 0, '0);
    cyc("done", 0, 0, 1, '0);
    for (int k = 0; k < 25; k++) begin
      if (k == 5) fill_rand();
      cyc("wipe", k == 5, k == 10, k == 10, 64'h1000 + 64'(k));
    end
    for (int k = 0; k < 25; k++) begin
      chk64("wipe.s0", bus.state_o[0][64*k +: 64], 64'h1000 + 64'(k));
      chk64("wipe.s1", bus.state_o[1][64*k +: 64], 64'h1000 + 64'(k));
    end
    cyc("post_wipe", 0, 0, 0, '0);

    // done + capture together from Full: wipe wins, err pulses
    fill(8'h3C, 8'hC3);
    cyc("cap2", 1, 0, 0, '0);
    fill_rand();
    cyc("done_vs_cap", 1, 0, 1, '0);
    for (int k = 0; k < 25; k++) cyc("wipe2", 0, 0, 0, {$urandom, $urandom});
    cyc("post_wipe2", 0, 0, 0, '0);

    // run + capture together: capture wins
    fill_rand();
    cyc("run_vs_cap", 1, 1, 0, '0);
    fill_rand();
    cyc("run_vs_cap_full", 1, 1, 0, '0);

    // Back-to-back squeezes
    for (int i = 0; i < 3; i++) begin
      fill_rand();
      cyc("b2b", 1, 0, 0, '0);
    end
    cyc("b2b_hold", 0, 0, 0, '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      fill_rand();
      cyc("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 29) == 0, {$urandom, $urandom});
    end
    for (int i = 0; i < 26; i++) cyc("drain", 0, 0, 0, {$urandom, $urandom});

    // Reset in the middle of a wipe: immediate clear, no resume
    fill_rand();
    cyc("cap3", 1, 0, 0, '0);
    cyc("done3", 0, 0, 1, '0);
    for (int k = 0; k < 7; k++) cyc("wipe3", 0, 0, 0, {$urandom, $urandom});
    rst = 1;
    #2;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 0;
    for (int k = 0; k < 5; k++) cyc("after_rst", 0, 0, 0, {$urandom, $urandom});
    fill_rand();
    cyc("cap_after_rst", 1, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
